// File: rtl/sel_pkg.sv
// Shared definitions for the register-select decoder: IR field positions,
// the immediate width default, the error counter width and the helper that
// turns the G strobes into a single field selection.
package sel_pkg;

  localparam int DATA_W    = 32;
  localparam int IDX_W     = 5;
  localparam int FIELD_W   = 4;

  // Instruction register field layout
  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 27;
  localparam int RA_HI     = 26;
  localparam int RA_LO     = 23;
  localparam int RB_HI     = 22;
  localparam int RB_LO     = 19;
  localparam int RC_HI     = 18;
  localparam int RC_LO     = 15;

  // Default width of the C immediate, taken from IR[C_W-1:0]
  localparam int C_W_DEF   = 19;

  // Rejected-request counter
  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  // Which IR field a request refers to; FSEL_NONE covers both "no G strobe"
  // and "more than one G strobe", which are rejected the same way.
  typedef enum logic [1:0] {
    FSEL_NONE = 2'd0,
    FSEL_RA   = 2'd1,
    FSEL_RB   = 2'd2,
    FSEL_RC   = 2'd3
  } fsel_e;

  // Exactly one strobe selects a field; anything else is invalid.
  function automatic fsel_e field_sel(input logic gra, input logic grb, input logic grc);
    fsel_e sel;
    case ({gra, grb, grc})
      3'b100:  sel = FSEL_RA;
      3'b010:  sel = FSEL_RB;
      3'b001:  sel = FSEL_RC;
      default: sel = FSEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/dec_5_32.sv
// Combinational 5-bit to 32-bit one-hot decoder with enable. With en low the
// output is all zeros.
module dec_5_32 (
  input  logic        en,
  input  logic [4:0]  idx,
  output logic [31:0] onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_bit
      assign onehot[gi] = en & (idx == 5'(gi));
    end
  endgenerate

endmodule

// File: rtl/sel_decode_32.sv
// Register-select decoder. Holds the IR, picks Ra/Rb/Rc on the G strobes and
// produces registered one-hot write / bus-drive enables one cycle after a
// request, together with valid/error pulses and a saturating error count.
// Optional feature: define SEL_DECODE_R0_ZERO_EN to turn a ba_out request on
// R0 into a zero_r0 pulse instead of driving R0 onto the bus.
module sel_decode_32
  import sel_pkg::*;
#(
  parameter int REG_COUNT = 16,
  parameter int C_W       = C_W_DEF
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 ir_in,
  input  logic [DATA_W-1:0]    bus_in,
  input  logic                 gra,
  input  logic                 grb,
  input  logic                 grc,
  input  logic                 r_in,
  input  logic                 r_out,
  input  logic                 ba_out,
  output logic [DATA_W-1:0]    ir_q,
  output logic [DATA_W-1:0]    reg_in_en,
  output logic [DATA_W-1:0]    reg_out_en,
  output logic [DATA_W-1:0]    c_sext,
  output logic                 sel_valid,
  output logic                 sel_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 zero_r0
);

  localparam int                SEXT_SH     = DATA_W - C_W;
  localparam logic [DATA_W-1:0] REG_COUNT_U = DATA_W'(REG_COUNT);

  logic [DATA_W-1:0]    ir_reg;

  fsel_e                fsel;
  logic                 req;
  logic                 drive_req;
  logic [FIELD_W-1:0]   field;
  logic [IDX_W-1:0]     idx;
  logic                 sel_ok;
  logic                 in_range;
  logic                 dec_en;
  logic                 r0_base;
  logic [DATA_W-1:0]    dec_onehot;
  logic [DATA_W-1:0]    reg_mask;
  logic [DATA_W-1:0]    dec_masked;
  logic signed [DATA_W-1:0] c_shl;

  logic [DATA_W-1:0]    reg_in_en_next;
  logic [DATA_W-1:0]    reg_out_en_next;
  logic                 sel_valid_next;
  logic                 sel_err_next;
  logic                 zero_r0_next;
  logic [ERR_CNT_W-1:0] err_cnt_next;

  logic [DATA_W-1:0]    reg_in_en_reg;
  logic [DATA_W-1:0]    reg_out_en_reg;
  logic                 sel_valid_reg;
  logic                 sel_err_reg;
  logic [ERR_CNT_W-1:0] err_cnt_reg;

  // Instruction register: loads from the bus on ir_in, otherwise holds.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ir_reg <= '0;
    end else if (ir_in) begin
      ir_reg <= bus_in;
    end
  end

  // Immediate sign extension: shift the C field to the top, then arithmetic
  // shift back down. Works for any C_W from 1 to 32 without a zero-width
  // replication.
  assign c_shl  = $signed(ir_reg << SEXT_SH);
  assign c_sext = c_shl >>> SEXT_SH;

  assign req       = r_in | r_out | ba_out;
  assign drive_req = r_out | ba_out;
  assign fsel      = field_sel(gra, grb, grc);
  assign sel_ok    = (fsel != FSEL_NONE);

  // Field extraction always works from the IR as it was before this edge, so
  // a same-cycle ir_in only affects the next request.
  always_comb begin
    field = '0;
    case (fsel)
      FSEL_RA: field = ir_reg[RA_HI:RA_LO];
      FSEL_RB: field = ir_reg[RB_HI:RB_LO];
      FSEL_RC: field = ir_reg[RC_HI:RC_LO];
      default: field = '0;
    endcase
  end

  assign idx      = {1'b0, field};
  assign in_range = ({{(DATA_W-IDX_W){1'b0}}, idx} < REG_COUNT_U);
  assign dec_en   = req & sel_ok & in_range;

  // Single decoder shared by the write and the drive enable vectors.
  dec_5_32 u_dec (
    .en     (dec_en),
    .idx    (idx),
    .onehot (dec_onehot)
  );

  // Registers that do not exist never see an enable, even if the range
  // check above is ever relaxed.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_mask
      assign reg_mask[gi] = (gi < REG_COUNT);
    end
  endgenerate

  assign dec_masked = dec_onehot & reg_mask;

`ifdef SEL_DECODE_R0_ZERO_EN
  // A base-address drive of R0 reads as zero; an explicit r_out still wins
  // and drives R0 normally.
  assign r0_base = ba_out & ~r_out & (idx == '0);
`else
  assign r0_base = 1'b0;
`endif

  // Next-state values for the one-cycle enable pulses and the error counter.
  always_comb begin
    reg_in_en_next  = r_in ? dec_masked : '0;
    reg_out_en_next = (drive_req & ~r0_base) ? dec_masked : '0;
    zero_r0_next    = dec_en & r0_base;
    sel_valid_next  = (|reg_in_en_next) | (|reg_out_en_next) | zero_r0_next;
    sel_err_next    = req & ~(sel_ok & in_range);
    err_cnt_next    = err_cnt_reg;
    if (sel_err_next && (err_cnt_reg != ERR_CNT_MAX)) begin
      err_cnt_next = err_cnt_reg + 1'b1;
    end
  end

  // Output registers: enables and pulses live for exactly one cycle.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      reg_in_en_reg  <= '0;
      reg_out_en_reg <= '0;
      sel_valid_reg  <= 1'b0;
      sel_err_reg    <= 1'b0;
      err_cnt_reg    <= '0;
    end else begin
      reg_in_en_reg  <= reg_in_en_next;
      reg_out_en_reg <= reg_out_en_next;
      sel_valid_reg  <= sel_valid_next;
      sel_err_reg    <= sel_err_next;
      err_cnt_reg    <= err_cnt_next;
    end
  end

`ifdef SEL_DECODE_R0_ZERO_EN
  logic zero_r0_reg;

  // R0 zero indication, same timing as the enables.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      zero_r0_reg <= 1'b0;
    end else begin
      zero_r0_reg <= zero_r0_next;
    end
  end

  assign zero_r0 = zero_r0_reg;
`else
  assign zero_r0 = 1'b0;
`endif

  assign ir_q       = ir_reg;
  assign reg_in_en  = reg_in_en_reg;
  assign reg_out_en = reg_out_en_reg;
  assign sel_valid  = sel_valid_reg;
  assign sel_err    = sel_err_reg;
  assign err_cnt    = err_cnt_reg;

endmodule

// File: tb/tb_sel_decode_32.sv
// Bench for sel_decode_32: two instances (REG_COUNT 16 and 8) share one
// stimulus stream. A directed vector table, hand-written reset / saturation /
// sign-extension sequences and a random phase are all checked against a
// cycle-level reference model built from the decode rules.
module tb_sel_decode_32;

  localparam int C_W = 19;

  logic        clk;
  logic        clr;
  logic        ir_in;
  logic [31:0] bus_in;
  logic        gra, grb, grc;
  logic        r_in, r_out, ba_out;

  logic [31:0] ir_q16, in16, out16, cs16;
  logic        v16, e16, z16;
  logic [7:0]  cnt16;
  logic [31:0] ir_q8, in8, out8, cs8;
  logic        v8, e8, z8;
  logic [7:0]  cnt8;

  int n_pass  = 0;
  int n_total = 0;

  sel_decode_32 #(.REG_COUNT(16), .C_W(C_W)) dut16 (
    .clk(clk), .clr(clr), .ir_in(ir_in), .bus_in(bus_in),
    .gra(gra), .grb(grb), .grc(grc),
    .r_in(r_in), .r_out(r_out), .ba_out(ba_out),
    .ir_q(ir_q16), .reg_in_en(in16), .reg_out_en(out16), .c_sext(cs16),
    .sel_valid(v16), .sel_err(e16), .err_cnt(cnt16), .zero_r0(z16)
  );

  sel_decode_32 #(.REG_COUNT(8), .C_W(C_W)) dut8 (
    .clk(clk), .clr(clr), .ir_in(ir_in), .bus_in(bus_in),
    .gra(gra), .grb(grb), .grc(grc),
    .r_in(r_in), .r_out(r_out), .ba_out(ba_out),
    .ir_q(ir_q8), .reg_in_en(in8), .reg_out_en(out8), .c_sext(cs8),
    .sel_valid(v8), .sel_err(e8), .err_cnt(cnt8), .zero_r0(z8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] ir;
    logic [31:0] in_en;
    logic [31:0] out_en;
    logic        valid;
    logic        err;
    logic        z;
    int          cnt;
  } m_t;

  m_t m16, m8;

  function automatic m_t m_reset();
    m_t r;
    r.ir = 0; r.in_en = 0; r.out_en = 0;
    r.valid = 0; r.err = 0; r.z = 0; r.cnt = 0;
    return r;
  endfunction

  function automatic m_t m_next(m_t s, logic iri, logic [31:0] bus,
                                logic [2:0] g, logic [2:0] rq, int rc);
    m_t n;
    int ng, idx;
    logic ri, ro, bo;
    n = s;
    n.in_en = 0; n.out_en = 0; n.valid = 0; n.err = 0; n.z = 0;
    if (iri) n.ir = bus;
    ri = rq[2]; ro = rq[1]; bo = rq[0];
    ng = int'(g[2]) + int'(g[1]) + int'(g[0]);
    if (ri || ro || bo) begin
      if (g[2])      idx = int'(s.ir[26:23]);
      else if (g[1]) idx = int'(s.ir[22:19]);
      else           idx = int'(s.ir[18:15]);
      if (ng != 1 || idx >= rc) begin
        n.err = 1;
        if (s.cnt < 255) n.cnt = s.cnt + 1;
      end else begin
        if (ri)       n.in_en  = 32'd1 << idx;
        if (ro || bo) n.out_en = 32'd1 << idx;
`ifdef SEL_DECODE_R0_ZERO_EN
        if (bo && !ro && idx == 0) begin
          n.out_en = 0;
          n.z      = 1;
        end
`endif
        n.valid = (n.in_en != 0) || (n.out_en != 0) || n.z;
      end
    end
    return n;
  endfunction

  function automatic logic [31:0] sext_m(logic [31:0] ir);
    longint v;
    v = longint'(ir) % (longint'(1) << C_W);
    if (v >= (longint'(1) << (C_W - 1))) v = v - (longint'(1) << C_W);
    return 32'(v);
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, " ir16"},    ir_q16, m16.ir);
    chk({tag, " in16"},    in16,   m16.in_en);
    chk({tag, " out16"},   out16,  m16.out_en);
    chk({tag, " csext16"}, cs16,   sext_m(m16.ir));
    chk({tag, " valid16"}, 32'(v16),   32'(m16.valid));
    chk({tag, " err16"},   32'(e16),   32'(m16.err));
    chk({tag, " cnt16"},   32'(cnt16), 32'(m16.cnt));
    chk({tag, " zero16"},  32'(z16),   32'(m16.z));
    chk({tag, " ir8"},     ir_q8,  m8.ir);
    chk({tag, " in8"},     in8,    m8.in_en);
    chk({tag, " out8"},    out8,   m8.out_en);
    chk({tag, " csext8"},  cs8,    sext_m(m8.ir));
    chk({tag, " valid8"},  32'(v8),    32'(m8.valid));
    chk({tag, " err8"},    32'(e8),    32'(m8.err));
    chk({tag, " cnt8"},    32'(cnt8),  32'(m8.cnt));
    chk({tag, " zero8"},   32'(z8),    32'(m8.z));
  endtask

  // One clock of stimulus; models advance on the same edge as the DUTs.
  task automatic cyc(input string tag, input logic iri, input logic [31:0] bus,
                     input logic [2:0] g, input logic [2:0] rq);
    ir_in = iri; bus_in = bus;
    {gra, grb, grc} = g;
    {r_in, r_out, ba_out} = rq;
    @(posedge clk);
    m16 = m_next(m16, iri, bus, g, rq, 16);
    m8  = m_next(m8,  iri, bus, g, rq, 8);
    #1;
    check_all(tag);
  endtask

  // ---------------- directed vector table (REG_COUNT=16 expectations) ----------------
  typedef struct {
    string       name;
    logic        iri;
    logic [31:0] bus;
    logic [2:0]  g;    // {gra,grb,grc}
    logic [2:0]  rq;   // {r_in,r_out,ba_out}
    logic [31:0] e_in;
    logic [31:0] e_out;
    logic        e_valid;
    logic        e_err;
    logic        e_z;
  } vec_t;

  function automatic vec_t mk(string nm, logic iri, logic [31:0] bus, logic [2:0] g,
                              logic [2:0] rq, logic [31:0] ei, logic [31:0] eo,
                              logic ev, logic ee, logic ez);
    vec_t v;
    v.name = nm; v.iri = iri; v.bus = bus; v.g = g; v.rq = rq;
    v.e_in = ei; v.e_out = eo; v.e_valid = ev; v.e_err = ee; v.e_z = ez;
    return v;
  endfunction

  vec_t tbl[14];

  initial begin
    logic [2:0] rg, rr;
    logic       ri;

    tbl[0]  = mk("load",      1'b1, 32'h0128_0000, 3'b000, 3'b000, 32'h0,   32'h0,   1'b0, 1'b0, 1'b0);
    tbl[1]  = mk("ra_write",  1'b0, 32'h0,         3'b100, 3'b100, 32'h4,   32'h0,   1'b1, 1'b0, 1'b0);
    tbl[2]  = mk("idle",      1'b0, 32'h0,         3'b000, 3'b000, 32'h0,   32'h0,   1'b0, 1'b0, 1'b0);
    tbl[3]  = mk("rb_rw",     1'b0, 32'h0,         3'b010, 3'b110, 32'h20,  32'h20,  1'b1, 1'b0, 1'b0);
    tbl[4]  = mk("multi_g",   1'b0, 32'h0,         3'b110, 3'b010, 32'h0,   32'h0,   1'b0, 1'b1, 1'b0);
    tbl[5]  = mk("g_only",    1'b0, 32'h0,         3'b010, 3'b000, 32'h0,   32'h0,   1'b0, 1'b0, 1'b0);
    tbl[6]  = mk("no_g",      1'b0, 32'h0,         3'b000, 3'b100, 32'h0,   32'h0,   1'b0, 1'b1, 1'b0);
`ifdef SEL_DECODE_R0_ZERO_EN
    tbl[7]  = mk("rc0_ba",    1'b0, 32'h0,         3'b001, 3'b001, 32'h0,   32'h0,   1'b1, 1'b0, 1'b1);
`else
    tbl[7]  = mk("rc0_ba",    1'b0, 32'h0,         3'b001, 3'b001, 32'h0,   32'h1,   1'b1, 1'b0, 1'b0);
`endif
    tbl[8]  = mk("rc0_rout",  1'b0, 32'h0,         3'b001, 3'b010, 32'h0,   32'h1,   1'b1, 1'b0, 1'b0);
    tbl[9]  = mk("load_same", 1'b1, 32'h0004_8000, 3'b100, 3'b100, 32'h4,   32'h0,   1'b1, 1'b0, 1'b0);
    tbl[10] = mk("ra0_write", 1'b0, 32'h0,         3'b100, 3'b100, 32'h1,   32'h0,   1'b1, 1'b0, 1'b0);
    tbl[11] = mk("rc9_write", 1'b0, 32'h0,         3'b001, 3'b100, 32'h200, 32'h0,   1'b1, 1'b0, 1'b0);
`ifdef SEL_DECODE_R0_ZERO_EN
    tbl[12] = mk("ra0_ba",    1'b0, 32'h0,         3'b100, 3'b001, 32'h0,   32'h0,   1'b1, 1'b0, 1'b1);
`else
    tbl[12] = mk("ra0_ba",    1'b0, 32'h0,         3'b100, 3'b001, 32'h0,   32'h1,   1'b1, 1'b0, 1'b0);
`endif
    tbl[13] = mk("load_neg",  1'b1, 32'h0007_FFFF, 3'b000, 3'b000, 32'h0,   32'h0,   1'b0, 1'b0, 1'b0);

    // Reset state
    clr = 1'b0; ir_in = 1'b0; bus_in = '0;
    {gra, grb, grc} = 3'b000; {r_in, r_out, ba_out} = 3'b000;
    m16 = m_reset(); m8 = m_reset();
    #12;
    check_all("reset");
    $display("reset: outputs checked while clr low");
    #1 clr = 1'b1;

    // Directed table
    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].name, tbl[i].iri, tbl[i].bus, tbl[i].g, tbl[i].rq);
      chk({tbl[i].name, " tbl_in"},    in16,        tbl[i].e_in);
      chk({tbl[i].name, " tbl_out"},   out16,       tbl[i].e_out);
      chk({tbl[i].name, " tbl_valid"}, 32'(v16),    32'(tbl[i].e_valid));
      chk({tbl[i].name, " tbl_err"},   32'(e16),    32'(tbl[i].e_err));
      chk({tbl[i].name, " tbl_zero"},  32'(z16),    32'(tbl[i].e_z));
      if (i == 4)  chk("multi_g cnt 0->1", 32'(cnt16), 32'd1);
      if (i == 11) chk("rc9 range err (8 regs)", 32'(e8), 32'd1);
      $display("vec %0d %s: in=%08h out=%08h valid=%0b err=%0b cnt=%0d zero=%0b",
               i, tbl[i].name, in16, out16, v16, e16, cnt16, z16);
    end

    // Sign extension of the C field
    chk("sext negative", cs16, 32'hFFFF_FFFF);
    cyc("load_pos", 1'b1, 32'h0003_FFFF, 3'b000, 3'b000);
    chk("sext positive", cs16, 32'h0003_FFFF);
    $display("sext: c_sext=%08h", cs16);

    // Error counter saturation
    for (int i = 0; i < 300; i++) cyc("sat", 1'b0, 32'h0, 3'b110, 3'b010);
    chk("err_cnt sat16", 32'(cnt16), 32'd255);
    chk("err_cnt sat8",  32'(cnt8),  32'd255);
    $display("saturation: err_cnt=%0d after 300 further errors", cnt16);

    // Reset while a request is pending
    cyc("pre_reset_load", 1'b1, 32'h0128_0000, 3'b000, 3'b000);
    cyc("pre_reset_req",  1'b0, 32'h0,         3'b100, 3'b110);
    chk("pre_reset valid", 32'(v16), 32'd1);
    #2 clr = 1'b0;
    m16 = m_reset(); m8 = m_reset();
    #1;
    check_all("async_reset");
    @(posedge clk);
    #1;
    check_all("held_reset");
    {gra, grb, grc} = 3'b000; {r_in, r_out, ba_out} = 3'b000;
    #2 clr = 1'b1;
    cyc("post_release", 1'b0, 32'h0, 3'b000, 3'b000);
    $display("reset mid-request: outputs cleared, no pulse after release");

    // Randomised phase
    for (int i = 0; i < 600; i++) begin
      ri = ($urandom_range(0, 3) == 0);
      rg = 3'($urandom_range(0, 7));
      rr = 3'($urandom_range(0, 7));
      cyc("rand", ri, $urandom, rg, rr);
    end
    $display("random: 600 cycles applied");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sel_decode_32.md
Name: sel_decode_32

Overview:
- Register-select decoder for the datapath: the decode-side counterpart of the bus-source encoder.
- Holds the instruction register (IR) and extracts the Ra/Rb/Rc fields from it.
- On control-unit strobes, drives registered one-hot register-file write enables and bus-drive enables, plus a sign-extended C constant.
- Sits between the control unit, the bus and the register file. The bus-source encoder consumes reg_out_en.

Parameters:
- REG_COUNT, 16: number of general-purpose registers decoded, legal range 1..32. Bits at or above REG_COUNT are always 0.
- C_W, 19: width of the immediate C field in IR[C_W-1:0], sign-extended to 32 bits.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous active-low reset.
- ir_in  in  1  load IR from bus_in this cycle.
- bus_in  in  32  datapath bus.
- gra  in  1  select the Ra field, IR[26:23].
- grb  in  1  select the Rb field, IR[22:19].
- grc  in  1  select the Rc field, IR[18:15].
- r_in  in  1  request a write enable for the selected register.
- r_out  in  1  request a bus-drive enable for the selected register.
- ba_out  in  1  base-address bus drive; same decode as r_out.
- ir_q  out  32  current IR contents.
- reg_in_en  out  32  one-hot register write enable.
- reg_out_en  out  32  one-hot register bus-drive enable.
- c_sext  out  32  IR[C_W-1:0] sign-extended to 32 bits.
- sel_valid  out  1  one-cycle pulse: registered enables are non-zero.
- sel_err  out  1  one-cycle pulse: the request was rejected.
- err_cnt  out  8  saturating count of rejected requests.
- zero_r0  out  1  R0 base-address zero indication (see Optional Feature).

Behaviour:
- Reset: asynchronous while clr=0. ir_q, reg_in_en, reg_out_en, sel_valid, sel_err, err_cnt and zero_r0 all go to 0; c_sext therefore reads 0.
- IR register: ir_q <= bus_in on a rising edge with ir_in=1, otherwise it holds.
- c_sext: combinational from ir_q.
- Request: a cycle with any of r_in, r_out or ba_out high.
- Field select: exactly one of gra/grb/grc high gives index idx (4 bits, zero-extended to 5).
- Latency: enables register on the edge after the request. They are valid for exactly one cycle, then return to 0 unless the request repeats.
- Decode rule: reg_in_en = onehot(idx) if r_in. reg_out_en = onehot(idx) if (r_out | ba_out). Otherwise each is 0.
- r_in and r_out together is legal: both vectors carry the same one-hot bit.
- Simultaneous ir_in and request: the decode uses the old ir_q, and the new IR applies from the next cycle.
- sel_valid = 1 in the same cycle the enables are non-zero.
- Error conditions, each producing all-zero enables, sel_err=1 for one cycle and err_cnt+1 (saturating at 255):
  - Request with zero of gra/grb/grc high, or more than one high.
  - idx >= REG_COUNT.
- A G strobe with no r_in/r_out/ba_out is ignored: no error.
- Reset mid-request: the outputs clear immediately; no pulse follows the release of clr.

Optional Feature:
- Macro SEL_DECODE_R0_ZERO_EN.
- Defined: ba_out with idx=0 gives reg_out_en[0]=0, and zero_r0 pulses 1 with the same timing as the enables. sel_valid is 1 in that cycle, so the bus reads 0 for the base address. r_out with idx=0 behaves normally.
- Undefined: zero_r0 is tied to 0, and ba_out is identical to r_out.

Decomposition:
- Shared package, sel_pkg: IR field bit positions (RA_HI/LO, RB_HI/LO, RC_HI/LO), C_W default, OPCODE_HI/LO, and the ERR_CNT_W=8 constant.
- One natural sub-module: dec_5_32, a combinational 5-bit to 32-bit one-hot decoder with enable. It is instantiated once and shared by both enable vectors.

Test Plan:
- Load and write-enable decode: ir_in with bus_in=0x01280000 (Ra=2, Rb=5); next cycle gra+r_in -> the following cycle reg_in_en=0x00000004, sel_valid=1; the cycle after, reg_in_en=0.
- Drive and write together: same IR, grb+r_out+r_in -> reg_out_en=0x00000020, reg_in_en=0x00000020, one cycle later.
- Sign extension: IR=0x0007FFFF -> c_sext=0xFFFFFFFF; IR=0x0003FFFF -> c_sext=0x0003FFFF.
- Multi-strobe error: gra+grb+r_out -> enables 0, sel_err pulse, err_cnt 0->1; 300 further errors -> err_cnt=255.
- Range check and R0 zeroing: REG_COUNT=8, Rc=9 with grc+r_in -> sel_err; with the macro defined, IR Ra=0 plus gra+ba_out -> reg_out_en=0, zero_r0=1.
- Reset and same-cycle load: clr low while a request is pending -> all outputs 0 asynchronously; ir_in plus a request in one cycle -> the decode uses the previous IR.
